// File: rtl/block_add_sequencer_pkg.sv
// Shared definitions for the block add sequencer: FSM encoding, slice width
// and the signed saturation constant generator used when ADD_SAT_EN is defined.
package block_add_sequencer_pkg;

  localparam int BLOCK_W = 8;
  localparam int MAX_W   = 64;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Most positive (neg=0) or most negative (neg=1) value of a width-bit signed number.
  function automatic logic [MAX_W-1:0] sat_value(input int width, input logic neg);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width - 1) begin
        v[i] = ~neg;
      end else if (i == width - 1) begin
        v[i] = neg;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/block_add_sequencer_cla8.sv
// 8-bit carry-lookahead block adder exporting block propagate/generate and the
// carry into bit 7 so the caller can chain slices and detect signed overflow.
module block_add_sequencer_cla8
  import block_add_sequencer_pkg::*;
(
  input  logic [BLOCK_W-1:0] x,
  input  logic [BLOCK_W-1:0] y,
  input  logic               c0,
  output logic [BLOCK_W-1:0] s,
  output logic               p,
  output logic               g,
  output logic               c7
);

  logic [BLOCK_W-1:0] bit_g;
  logic [BLOCK_W-1:0] bit_p;
  logic [BLOCK_W:0]   carry;

  assign bit_g = x & y;
  assign bit_p = x ^ y;

  // Prefix generate/propagate form each carry directly from c0.
  always_comb begin
    logic pre_g;
    logic pre_p;
    pre_g    = 1'b0;
    pre_p    = 1'b1;
    carry    = '0;
    carry[0] = c0;
    for (int i = 0; i < BLOCK_W; i++) begin
      pre_g        = bit_g[i] | (bit_p[i] & pre_g);
      pre_p        = pre_p & bit_p[i];
      carry[i+1]   = pre_g | (pre_p & c0);
    end
    g = pre_g;
    p = pre_p;
  end

  assign s  = bit_p ^ carry[BLOCK_W-1:0];
  assign c7 = carry[BLOCK_W-1];

endmodule

// File: rtl/block_add_sequencer.sv
// Wide add/subtract controller that time-shares one 8-bit block adder over
// NUM_BLOCKS byte slices, LSB first. Define ADD_SAT_EN for signed saturation.
module block_add_sequencer
  import block_add_sequencer_pkg::*;
#(
  parameter  int NUM_BLOCKS = 4,
  localparam int W          = BLOCK_W * NUM_BLOCKS
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int              IDX_W = $clog2(NUM_BLOCKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

  state_t             state;
  logic [W-1:0]       a_reg;
  logic [W-1:0]       b_reg;
  logic               carry;
  logic [IDX_W-1:0]   idx;

  logic [BLOCK_W-1:0] slice_x;
  logic [BLOCK_W-1:0] slice_y;
  logic [BLOCK_W-1:0] blk_s;
  logic               blk_p;
  logic               blk_g;
  logic               blk_c7;
  logic               carry_next;
  logic               last_slice;

  assign slice_x    = a_reg[int'(idx)*BLOCK_W +: BLOCK_W];
  assign slice_y    = b_reg[int'(idx)*BLOCK_W +: BLOCK_W];
  assign carry_next = blk_g | (blk_p & carry);
  assign last_slice = (idx == LAST_IDX);

  block_add_sequencer_cla8 u_cla8 (
    .x  (slice_x),
    .y  (slice_y),
    .c0 (carry),
    .s  (blk_s),
    .p  (blk_p),
    .g  (blk_g),
    .c7 (blk_c7)
  );

`ifdef ADD_SAT_EN
  localparam logic [W-1:0] SAT_POS = W'(sat_value(W, 1'b0));
  localparam logic [W-1:0] SAT_NEG = W'(sat_value(W, 1'b1));
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= a;
            b_reg    <= b ^ {W{sub}};
            carry    <= sub ? 1'b1 : cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[int'(idx)*BLOCK_W +: BLOCK_W] <= blk_s;
          carry <= carry_next;
          if (last_slice) begin
            cout      <= carry_next;
            ovf       <= blk_c7 ^ carry_next;
            idx       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef ADD_SAT_EN
            // Overriding the whole word discards the top slice just written.
            if (blk_c7 ^ carry_next) begin
              sum <= a_reg[W-1] ? SAT_NEG : SAT_POS;
            end
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // Returning to IDLE first means a waiting request is taken next cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_add_sequencer.sv
// Directed and random self-checking bench for block_add_sequencer (NUM_BLOCKS=4);
// expectations follow ADD_SAT_EN when the bench is built with it.
module tb_block_add_sequencer;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] obs_sum;
  logic        obs_cout;
  logic        obs_ovf;
  int          latency;

  block_add_sequencer #(.NUM_BLOCKS(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present a request and hold it until the accepting edge has passed.
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic sv, input logic cv);
    int n;
    @(negedge clock);
    a = av; b = bv; sub = sv; cin = cv; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic waitResult();
    latency = 0;
    do begin
      @(posedge clock);
      #1 latency++;
    end while (!out_valid && latency < 50);
    if (!out_valid) checkOutput("result_timeout", {31'b0, out_valid}, 32'd1);
    obs_sum  = sum;
    obs_cout = cout;
    obs_ovf  = ovf;
  endtask

  task automatic popResult(input int stall);
    repeat (stall) @(negedge clock);
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
  endtask

  task automatic modelOp(input logic [31:0] av, input logic [31:0] bv, input logic sv, input logic cv,
                         output logic [31:0] es, output logic ec, output logic eo);
    logic [31:0] bb;
    logic [32:0] full;
    bb   = sv ? ~bv : bv;
    full = {1'b0, av} + {1'b0, bb} + {32'b0, (sv ? 1'b1 : cv)};
    es   = full[31:0];
    ec   = full[32];
    eo   = (av[31] == bb[31]) && (full[31] != av[31]);
`ifdef ADD_SAT_EN
    if (eo) es = av[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
  endtask

  initial begin
    logic [31:0] es;
    logic        ec;
    logic        eo;
    logic [31:0] held_sum;
    logic        held_cout;
    logic        held_ovf;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    #12;
    checkOutput("reset_in_ready",  {31'b0, in_ready},  32'd1);
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_sum",       sum,                32'd0);
    checkOutput("reset_cout",      {31'b0, cout},      32'd0);
    checkOutput("reset_ovf",       {31'b0, ovf},       32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Carry ripple through all four slices
    applyStimulus(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    waitResult();
    checkOutput("ripple_latency", latency, 32'd4);
    checkOutput("ripple_sum",  obs_sum,           32'h0000_0000);
    checkOutput("ripple_cout", {31'b0, obs_cout}, 32'd1);
    checkOutput("ripple_ovf",  {31'b0, obs_ovf},  32'd0);
    popResult(0);

    // Signed overflow
    applyStimulus(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    waitResult();
`ifdef ADD_SAT_EN
    checkOutput("ovf_sum",  obs_sum, 32'h7FFF_FFFF);
`else
    checkOutput("ovf_sum",  obs_sum, 32'h8000_0000);
`endif
    checkOutput("ovf_ovf",  {31'b0, obs_ovf},  32'd1);
    checkOutput("ovf_cout", {31'b0, obs_cout}, 32'd0);
    popResult(0);

    // Subtraction with and without borrow
    applyStimulus(32'd5, 32'd7, 1'b1, 1'b0);
    waitResult();
    checkOutput("sub57_sum",  obs_sum,           32'hFFFF_FFFE);
    checkOutput("sub57_cout", {31'b0, obs_cout}, 32'd0);
    checkOutput("sub57_ovf",  {31'b0, obs_ovf},  32'd0);
    popResult(0);
    applyStimulus(32'd7, 32'd5, 1'b1, 1'b1);
    waitResult();
    checkOutput("sub75_sum",  obs_sum,           32'd2);
    checkOutput("sub75_cout", {31'b0, obs_cout}, 32'd1);
    popResult(1);

    // Backpressure: hold result 10 cycles with a pending request
    applyStimulus(32'h0000_1234, 32'h0000_0F0F, 1'b0, 1'b1);
    waitResult();
    checkOutput("bp_sum", obs_sum, 32'h0000_2144);
    held_sum = sum; held_cout = cout; held_ovf = ovf;
    @(negedge clock);
    a = 32'h0000_0010; b = 32'h0000_0020; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      checkOutput("bp_hold_sum",   sum,                held_sum);
      checkOutput("bp_hold_flags", {30'b0, cout, ovf}, {30'b0, held_cout, held_ovf});
      checkOutput("bp_in_ready",   {31'b0, in_ready},  32'd0);
      checkOutput("bp_out_valid",  {31'b0, out_valid}, 32'd1);
    end
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    checkOutput("bp_pop_valid",    {31'b0, out_valid}, 32'd0);
    checkOutput("bp_pop_in_ready", {31'b0, in_ready},  32'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
    checkOutput("bp_accept_next", {31'b0, in_ready}, 32'd0);
    waitResult();
    checkOutput("bp_pending_sum", obs_sum, 32'h0000_0030);
    popResult(0);

    // Reset during the second RUN cycle aborts the operation
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    checkOutput("abort_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("abort_in_ready",  {31'b0, in_ready},  32'd1);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      checkOutput("abort_no_result", {31'b0, out_valid}, 32'd0);
    end
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    waitResult();
    checkOutput("after_abort_sum",  obs_sum,                  32'h2345_6789);
    checkOutput("after_abort_flag", {30'b0, obs_cout, obs_ovf}, 32'd0);
    popResult(0);

    // Random operations against a 33-bit behavioural model
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;
      logic        rc;
      ra = $urandom;
      rb = $urandom;
      if (i % 10 == 0) rb = {~ra[31], $urandom_range(0, 3) == 0 ? ~ra[30:0] : rb[30:0]};
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      modelOp(ra, rb, rs, rc, es, ec, eo);
      applyStimulus(ra, rb, rs, rc);
      waitResult();
      checkOutput("rand_sum",  obs_sum,           es);
      checkOutput("rand_cout", {31'b0, obs_cout}, {31'b0, ec});
      checkOutput("rand_ovf",  {31'b0, obs_ovf},  {31'b0, eo});
      popResult($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
